pc_next_unit: RTL
=================

// Module: pc_next_unit
// PURPOSE
//   Program-counter register plus next-PC selection. Generalises the 2:1 PC mux
//   to a prioritised 4-source select: sequential, branch, jump, jump-register.
//   Adds stall hold and a DEPTH-entry circular return-address stack (RAS) for
//   call/return. Sits at the head of fetch; pc drives instruction-memory address.
// PARAMETERS
//   N         32     address width (bits)
//   RESET_PC  0      pc value loaded on reset (N bits)
//   INC       4      sequential increment / link offset
//   DEPTH     4      RAS entries (>=2, power of two)
// PORTS
//   clk            in   1      rising-edge clock
//   rst_n          in   1      synchronous active-low reset
//   stall          in   1      hold pc and RAS; all other controls ignored
//   branch_taken   in   1      select branch_target
//   branch_target  in   N      branch destination
//   jump           in   1      select jump_target
//   jump_target    in   N      jump destination
//   jr             in   1      select jr_target (register jump)
//   jr_target      in   N      register-jump destination (architectural)
//   link           in   1      call: push pc+INC onto RAS
//   ret            in   1      return: pop RAS (valid only with jr)
//   pc             out  N      current pc (registered)
//   pc_plus_inc    out  N      pc+INC, combinational, wraps mod 2^N
//   ras_top        out  N      top RAS entry (0 when empty)
//   ras_count      out  clog2(DEPTH)+1  occupied entries
//   ras_overflow   out  1      sticky; set on push while full
//   ret_mispredict out  1      registered 1-cycle pulse; see below
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): pc=RESET_PC, ras_count=0, ptr=0, ras_overflow=0,
//     ret_mispredict=0; reset wins over stall and every control.
//   - Latency: one cycle; controls sampled at edge k determine pc after edge k.
//   - Priority when !stall: jr > jump > branch_taken > sequential (pc+INC).
//   - jr && ret: next pc = ras_top if ras_count>0, else jr_target.
//     ret_mispredict=1 next cycle if count==0 or ras_top!=jr_target; else 0.
//   - ret without jr: ignored (no pop, no pulse).
//   - link: push pc+INC at ptr, ptr=ptr+1 mod DEPTH, count=min(count+1,DEPTH).
//     Push while full overwrites oldest entry; ras_overflow set until reset.
//   - Pop: ptr=ptr-1 mod DEPTH, count-1. Pop while empty: no state change.
//   - link && jr && ret same cycle: pop then push (top replaced by pc+INC);
//     count unchanged if nonzero, becomes 1 if empty.
//   - link is independent of target select (jal = jump && link).
//   - stall=1: pc, RAS, pointers hold; ret_mispredict forced 0.
//   - All address arithmetic mod 2^N; pc=2^N-INC wraps to 0 sequentially.
// TESTING
//   1 reset: rst_n=0 one edge -> pc=RESET_PC, ras_count=0, flags 0.
//   2 select: pc=0x10, branch_taken=1 tgt 0x40, jump=1 tgt 0x80 -> pc=0x80;
//     next cycle jr=1 tgt 0x20 with jump=1 -> pc=0x20; idle -> pc=0x24.
//   3 call/return: pc=0x100 jump+link tgt 0x400 -> pc=0x400, ras_top=0x104;
//     jr+ret jr_target=0x104 -> pc=0x104, count=0, ret_mispredict=0.
//   4 overflow: 5 pushes into DEPTH=4 -> count=4, ras_overflow=1, oldest lost;
//     4 pops return last four links in LIFO order.
//   5 empty/mismatch: jr+ret on empty, jr_target=0x300 -> pc=0x300,
//     ret_mispredict=1; push 0x104 then jr+ret tgt 0x200 -> pc=0x104, pulse=1.
//   6 stall/wrap: stall=1 with jump -> pc unchanged 3 cycles; pc=0xFFFFFFFC
//     idle -> pc=0; rst_n=0 mid-call -> RAS cleared, pc=RESET_PC.

Source files
------------

// File: rtl/pc_next_unit.sv
// pc_next_unit: the program-counter register and its next-PC selection, at the head of fetch.
// The next PC comes from one of four sources in priority order:
// jump-register, jump, taken branch, then sequential.
// A circular return-address stack predicts the target of each return.
// A stall freezes all state.
module pc_next_unit #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             INC      = 4,
    parameter int             DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [N-1:0]             branch_target,
    input  logic                     jump,
    input  logic [N-1:0]             jump_target,
    input  logic                     jr,
    input  logic [N-1:0]             jr_target,
    input  logic                     link,
    input  logic                     ret,
    output logic [N-1:0]             pc,
    output logic [N-1:0]             pc_plus_inc,
    output logic [N-1:0]             ras_top,
    output logic [$clog2(DEPTH):0]   ras_count,
    output logic                     ras_overflow,
    output logic                     ret_mispredict
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N-1:0]  ras_mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_dec;
    logic [PW-1:0] wr_idx;
    logic          ras_empty;
    logic          ras_full;
    logic          ret_valid;
    logic          do_pop;
    logic          do_push;
    logic          mispredict_next;
    logic [N-1:0]  pc_next;

    // Decode the RAS occupancy and pick the next pc by priority.
    // A simultaneous pop and push rewrites the current top slot in place.
    always_comb begin
        ptr_dec         = ptr - PW'(1);
        ras_empty       = (ras_count == '0);
        ras_full        = (ras_count == CW'(DEPTH));
        ras_top         = ras_empty ? '0 : ras_mem[ptr_dec];
        pc_plus_inc     = pc + N'(INC);
        ret_valid       = jr && ret;
        do_pop          = ret_valid && !ras_empty;
        do_push         = link;
        wr_idx          = do_pop ? ptr_dec : ptr;
        mispredict_next = ret_valid && (ras_empty || (ras_top != jr_target));
        pc_next         = pc_plus_inc;
        if (jr) begin
            pc_next = do_pop ? ras_top : jr_target;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

    // Program-counter register: reset wins, and a stall holds the pc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (!stall) begin
            pc <= pc_next;
        end
    end

    // RAS pointer, occupancy and sticky overflow.
    // A pop combined with a push leaves both unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr          <= '0;
            ras_count    <= '0;
            ras_overflow <= 1'b0;
        end else if (!stall) begin
            if (do_pop && do_push) begin
                ptr       <= ptr;
                ras_count <= ras_count;
            end else if (do_pop) begin
                ptr       <= ptr_dec;
                ras_count <= ras_count - CW'(1);
            end else if (do_push) begin
                ptr <= ptr + PW'(1);
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CW'(1);
                end
            end
        end
    end

    // RAS storage: not reset, because occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (rst_n && !stall && do_push) begin
            ras_mem[wr_idx] <= pc_plus_inc;
        end
    end

    // One-cycle pulse when a return's predicted target disagrees with the architectural one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_mispredict <= 1'b0;
        end else if (stall) begin
            ret_mispredict <= 1'b0;
        end else begin
            ret_mispredict <= mispredict_next;
        end
    end

endmodule
